// File: rtl/wam_pkg.sv
// Shared constants for the whack-a-mole input path.
// No logic; timing defaults and counter widths only.
// Backpressure: not applicable.
package wam_pkg;

    localparam int N_BTN_DEF           = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int STUCK_CYCLES_DEF    = 50000;
    localparam int HOLD_W              = 16;

endpackage : wam_pkg

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, consecutive-sample debounce, stuck detection, edge pulses.
// Latency: level/press follow a raw change by DEBOUNCE_CYCLES+2 edges.
// Backpressure: none; free-running, ena low clears all state.
module btn_debounce_ch
    import wam_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic stuck
);

    localparam int                 DB_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(STUCK_CYCLES - 1);

    logic              s1;
    logic              s2;
    logic              stable;
    logic              stable_d;
    logic              stuck_d;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            stuck_d  <= 1'b0;
            stuck    <= 1'b0;
            db_cnt   <= '0;
            hold_cnt <= '0;
        end else if (!ena) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            stuck_d  <= 1'b0;
            stuck    <= 1'b0;
            db_cnt   <= '0;
            hold_cnt <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            stuck_d  <= stuck;

            // A single agreeing sample restarts the count, rejecting short glitches.
            if (s2 == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (!stable) begin
                hold_cnt <= '0;
                stuck    <= 1'b0;
            end else if (!stuck) begin
                if (hold_cnt == HOLD_LAST) begin
                    stuck <= 1'b1;
                end
                if (hold_cnt != '1) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    // A release that follows a stuck period is suppressed: the level already dropped.
    assign level = stable & ~stuck;
    assign press = ena & stable & ~stable_d;
    assign rel   = ena & stable_d & ~stable & ~stuck_d;

endmodule : btn_debounce_ch

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw pushbuttons into clean levels, press/release pulses and stuck flags.
// Latency: DEBOUNCE_CYCLES+2 edges from raw change to level/pulse.
// Backpressure: none; outputs are free-running, ena low acts as a synchronous clear.
module btn_conditioner
    import wam_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_stuck,
    output logic             any_stuck
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .ena  (ena),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i]),
            .stuck(btn_stuck[i])
        );
    end

    assign any_stuck = |btn_stuck;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=20.
// Directed vector table, hand sequences for reset/ena, then random traffic against a reference model.
module tb_btn_conditioner;

    localparam int N = 8;
    localparam int D = 4;
    localparam int S = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_stuck;
    logic         any_stuck;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .STUCK_CYCLES(S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_stuck(btn_stuck), .any_stuck(any_stuck)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stable flips once the last D synchronised samples all disagree;
    // stuck is a pure function of how long ago the button became stable.
    int           t = 0;
    logic [N-1:0] m_stable, m_stuck, m_pstable, m_pstuck;
    logic [N-1:0] m_dly [2];
    logic [D-1:0] m_win [N];
    int           m_rise [N];

    function automatic void model_clear();
        m_stable  = '0;
        m_stuck   = '0;
        m_pstable = '0;
        m_pstuck  = '0;
        m_dly[0]  = '0;
        m_dly[1]  = '0;
        for (int c = 0; c < N; c++) begin
            m_win[c]  = '0;
            m_rise[c] = 0;
        end
    endfunction

    function automatic void model_edge();
        logic [N-1:0] seen;
        logic old_st, old_sk, new_st;
        t++;
        if (!rst_n || !ena) begin
            model_clear();
            return;
        end
        seen     = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = btn_raw;
        for (int c = 0; c < N; c++) begin
            m_win[c] = {m_win[c][D-2:0], seen[c]};
            old_st = m_stable[c];
            old_sk = m_stuck[c];
            new_st = old_st;
            if (old_st ? (m_win[c] == '0) : (m_win[c] == '1)) new_st = ~old_st;
            if (new_st && !old_st) m_rise[c] = t;
            m_stuck[c]   = old_st && ((t - m_rise[c]) >= S);
            m_pstable[c] = old_st;
            m_pstuck[c]  = old_sk;
            m_stable[c]  = new_st;
        end
    endfunction

    function automatic logic [4*N:0] model_out();
        logic [N-1:0] lv, pr, rl;
        lv = m_stable & ~m_stuck;
        pr = {N{ena & rst_n}} & m_stable & ~m_pstable;
        rl = {N{ena & rst_n}} & m_pstable & ~m_stable & ~m_pstuck;
        return {lv, pr, rl, m_stuck, |m_stuck};
    endfunction

    function automatic logic [4*N:0] dut_out();
        return {btn_level, btn_press, btn_release, btn_stuck, any_stuck};
    endfunction

    task automatic cmp(input string name, input logic [4*N:0] act, input logic [4*N:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got lvl/prs/rel/stk/any=%h required %h", name, t, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp("model", dut_out(), model_out());
    endtask

    typedef struct {
        string        name;
        logic [N-1:0] raw;
        int           steps;
        logic [N-1:0] lvl, prs, rel, stk;
    } vec_t;

    vec_t vecs[21];

    initial begin
        model_clear();
        vecs[0]  = '{"press_wait",  8'h01, 5,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{"press_edge6", 8'h01, 1,  8'h01, 8'h01, 8'h00, 8'h00};
        vecs[2]  = '{"press_once",  8'h01, 1,  8'h01, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{"rel_wait",    8'h00, 5,  8'h01, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{"rel_edge6",   8'h00, 1,  8'h00, 8'h00, 8'h01, 8'h00};
        vecs[5]  = '{"rel_once",    8'h00, 1,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{"glitch_a",    8'h08, 3,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{"glitch_gap",  8'h00, 1,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{"glitch_b",    8'h08, 3,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{"glitch_end",  8'h00, 8,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{"stk_press",   8'h20, 6,  8'h20, 8'h20, 8'h00, 8'h00};
        vecs[11] = '{"stk_before",  8'h20, 19, 8'h20, 8'h00, 8'h00, 8'h00};
        vecs[12] = '{"stk_set",     8'h20, 1,  8'h00, 8'h00, 8'h00, 8'h20};
        vecs[13] = '{"stk_hold",    8'h20, 14, 8'h00, 8'h00, 8'h00, 8'h20};
        vecs[14] = '{"stk_relwait", 8'h00, 5,  8'h00, 8'h00, 8'h00, 8'h20};
        vecs[15] = '{"stk_clear",   8'h00, 2,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[16] = '{"all_wait",    8'hFF, 5,  8'h00, 8'h00, 8'h00, 8'h00};
        vecs[17] = '{"all_press",   8'hFF, 1,  8'hFF, 8'hFF, 8'h00, 8'h00};
        vecs[18] = '{"all_hold",    8'hFF, 1,  8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[19] = '{"all_rel",     8'h00, 6,  8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[20] = '{"all_idle",    8'h00, 1,  8'h00, 8'h00, 8'h00, 8'h00};

        // Reset state
        repeat (2) step();
        cmp("reset_outs", dut_out(), '0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 21; i++) begin
            btn_raw = vecs[i].raw;
            repeat (vecs[i].steps) step();
            cmp(vecs[i].name, dut_out(),
                {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].stk, |vecs[i].stk});
        end

        // Reset two cycles into a debounce on button 1
        btn_raw = 8'h02;
        repeat (2) step();
        rst_n = 1'b0;
        model_clear();
        #1;
        cmp("rst_async", dut_out(), '0);
        repeat (2) step();
        cmp("rst_held", dut_out(), '0);
        rst_n = 1'b1;
        repeat (5) step();
        cmp("rst_redb_wait", dut_out(), '0);
        step();
        cmp("rst_redb_press", dut_out(), {8'h02, 8'h02, 8'h00, 8'h00, 1'b0});

        // ena low while button 2 is stably pressed
        btn_raw = 8'h06;
        repeat (6) step();
        cmp("ena_pre", dut_out(), {8'h06, 8'h04, 8'h00, 8'h00, 1'b0});
        ena = 1'b0;
        step();
        cmp("ena_clear", dut_out(), '0);
        ena = 1'b1;
        repeat (5) step();
        cmp("ena_redb_wait", dut_out(), '0);
        step();
        cmp("ena_redb_press", dut_out(), {8'h06, 8'h06, 8'h00, 8'h00, 1'b0});

        // Random traffic; slow toggles so debounce and stuck both get exercised
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] flip;
            flip = '0;
            for (int c = 0; c < N; c++) flip[c] = ($urandom_range(0, 11) == 0);
            btn_raw = btn_raw ^ flip;
            ena = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_clear();
                #1;
                cmp("rand_rst", dut_out(), '0);
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_btn_conditioner
